// File: rtl/mem_loader.sv
// Framed byte-stream loader feeding the 256 x 8 data memory write port: address, length, payload.
// Optional trailing checksum byte is enabled by defining CHECKSUM_EN.
module mem_loader #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              mem_write_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int IDLE_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {S_IDLE, S_LEN, S_DATA, S_CHK, S_DONE} state_t;

    state_t              state_q;
    logic                ready_q;
    logic                busy_q;
    logic                done_q;
    logic                err_q;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [ADDR_W-1:0]   ptr_q;
    logic [ADDR_W:0]     count_q;
    logic [IDLE_W-1:0]   idle_q;
`ifdef CHECKSUM_EN
    logic [DATA_W-1:0]   sum_q;
`endif
    logic                accept;

    // Reset must block acceptance combinationally so a byte offered during rst is never taken.
    assign in_ready       = ready_q && !rst;
    assign accept         = in_valid && in_ready;
    assign mem_write_en   = we_q;
    assign mem_addr       = addr_q;
    assign mem_write_data = wdata_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign err            = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            ptr_q   <= '0;
            count_q <= '0;
            idle_q  <= '0;
`ifdef CHECKSUM_EN
            sum_q   <= '0;
`endif
        end else begin
            we_q   <= 1'b0;
            done_q <= 1'b0;
            if (accept) idle_q <= '0;
            case (state_q)
                S_IDLE: if (accept) begin
                    ptr_q   <= ADDR_W'(in_data);
                    err_q   <= 1'b0;
                    busy_q  <= 1'b1;
                    state_q <= S_LEN;
`ifdef CHECKSUM_EN
                    sum_q   <= in_data;
`endif
                end
                S_LEN: if (accept) begin
                    // A zero length byte encodes a full 256-byte frame.
                    count_q <= (in_data == '0) ? {1'b1, {ADDR_W{1'b0}}} : (ADDR_W+1)'(in_data);
                    state_q <= S_DATA;
`ifdef CHECKSUM_EN
                    sum_q   <= sum_q + in_data;
`endif
                end
                S_DATA: if (accept) begin
                    we_q    <= 1'b1;
                    addr_q  <= ptr_q;
                    wdata_q <= in_data;
                    ptr_q   <= ptr_q + ADDR_W'(1);
                    count_q <= count_q - (ADDR_W+1)'(1);
`ifdef CHECKSUM_EN
                    sum_q   <= sum_q + in_data;
                    if (count_q == (ADDR_W+1)'(1)) state_q <= S_CHK;
`else
                    if (count_q == (ADDR_W+1)'(1)) begin
                        state_q <= S_DONE;
                        ready_q <= 1'b0;
                        done_q  <= 1'b1;
                    end
`endif
                end
`ifdef CHECKSUM_EN
                S_CHK: if (accept) begin
                    state_q <= S_DONE;
                    ready_q <= 1'b0;
                    done_q  <= 1'b1;
                    if (DATA_W'(sum_q + in_data) != '0) err_q <= 1'b1;
                end
`endif
                default: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
            if (TIMEOUT > 0 && !accept &&
                (state_q == S_LEN || state_q == S_DATA || state_q == S_CHK)) begin
                if (idle_q == IDLE_LAST) begin
                    state_q <= S_IDLE;
                    err_q   <= 1'b1;
                    busy_q  <= 1'b0;
                    idle_q  <= '0;
                end else begin
                    idle_q <= idle_q + IDLE_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_loader.sv
// Scoreboard bench for mem_loader: expected writes queued as bytes are driven, checked as writes appear.
module tb_mem_loader;

    localparam int TO = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready;
    logic       mem_write_en;
    logic [7:0] mem_addr;
    logic [7:0] mem_write_data;
    logic       busy;
    logic       done;
    logic       err;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int write_count = 0;
    int done_count = 0;
    int gap_count = 0;
    int last_wr_cyc = -1;
    logic [15:0] exp_q[$];
    logic [7:0]  pl_q[$];
    logic [7:0]  mem_model [256];

    mem_loader #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .mem_write_en(mem_write_en), .mem_addr(mem_addr),
        .mem_write_data(mem_write_data), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Monitor: the memory model follows the write port; every write is checked against the scoreboard.
    always @(negedge clk) begin
        logic [15:0] exp;
        cyc++;
        if (done) done_count++;
        if (mem_write_en) begin
            write_count++;
            if (last_wr_cyc >= 0 && cyc != last_wr_cyc + 1) gap_count++;
            last_wr_cyc = cyc;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL write_unexpected: got addr=%h data=%h, required no write", mem_addr, mem_write_data);
            end else begin
                exp = exp_q.pop_front();
                if ({mem_addr, mem_write_data} !== exp) begin
                    errors++;
                    $display("FAIL write_match: got addr=%h data=%h, required addr=%h data=%h",
                             mem_addr, mem_write_data, exp[15:8], exp[7:0]);
                end else begin
                    $display("write addr=%h data=%h", mem_addr, mem_write_data);
                end
            end
            mem_model[mem_addr] = mem_write_data;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_wait: in_ready stayed %b, required 1 within 50 cycles", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [7:0] l, input logic bad_chk);
        logic [7:0] ptr;
        logic [7:0] sum;
        ptr = a;
        sum = a + l;
        $display("frame addr=%h len=%h bytes=%0d badchk=%0d", a, l, pl_q.size(), bad_chk);
        send_byte(a);
        send_byte(l);
        foreach (pl_q[i]) begin
            exp_q.push_back({ptr, pl_q[i]});
            ptr = ptr + 8'd1;
            sum = sum + pl_q[i];
            send_byte(pl_q[i]);
        end
`ifdef CHECKSUM_EN
        send_byte(bad_chk ? (8'h00 - sum + 8'h01) : (8'h00 - sum));
`endif
        checks++;
        if ({done, busy, in_ready} !== 3'b110) begin
            errors++;
            $display("FAIL done_cycle: got done=%b busy=%b ready=%b, required 1 1 0", done, busy, in_ready);
        end
        @(posedge clk); #1;
        checks++;
        if ({done, busy, in_ready} !== 3'b001) begin
            errors++;
            $display("FAIL after_done: got done=%b busy=%b ready=%b, required 0 0 1", done, busy, in_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({in_ready, busy, done, err, mem_write_en} !== 5'b0 || mem_addr !== 8'h00 || mem_write_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_state: got ready=%b busy=%b done=%b err=%b we=%b addr=%h data=%h, required all 0",
                     in_ready, busy, done, err, mem_write_en, mem_addr, mem_write_data);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got ready=%b busy=%b, required 1 0", in_ready, busy);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int dc, wc;
        dc = done_count;
        wc = write_count;
        gap_count = 0;
        last_wr_cyc = -1;
        pl_q = '{8'hAA, 8'hBB, 8'hCC};
        send_frame(8'h10, 8'h03, 1'b0);
        checks++;
        if (write_count - wc !== 3 || gap_count !== 0 || done_count - dc !== 1) begin
            errors++;
            $display("FAIL b2b_counts: got writes=%0d gaps=%0d dones=%0d, required 3 0 1",
                     write_count - wc, gap_count, done_count - dc);
        end
        checks++;
        if ({mem_model[8'h10], mem_model[8'h11], mem_model[8'h12]} !== 24'hAABBCC) begin
            errors++;
            $display("FAIL b2b_mem: got %h %h %h, required AA BB CC",
                     mem_model[8'h10], mem_model[8'h11], mem_model[8'h12]);
        end
    endtask

    task automatic test_wrap();
        pl_q = '{8'h11, 8'h22, 8'h33};
        send_frame(8'hFE, 8'h03, 1'b0);
        checks++;
        if ({mem_model[8'hFE], mem_model[8'hFF], mem_model[8'h00]} !== 24'h112233) begin
            errors++;
            $display("FAIL wrap_mem: got %h %h %h, required 11 22 33",
                     mem_model[8'hFE], mem_model[8'hFF], mem_model[8'h00]);
        end
    endtask

    task automatic test_full_frame();
        int wc, bad;
        wc = write_count;
        bad = 0;
        gap_count = 0;
        last_wr_cyc = -1;
        pl_q.delete();
        for (int i = 0; i < 256; i++) pl_q.push_back(8'(i));
        send_frame(8'h00, 8'h00, 1'b0);
        checks++;
        if (write_count - wc !== 256 || gap_count !== 0) begin
            errors++;
            $display("FAIL full_count: got writes=%0d gaps=%0d, required 256 0", write_count - wc, gap_count);
        end
        for (int i = 0; i < 256; i++) if (mem_model[i] !== 8'(i)) bad++;
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL full_mem: got %0d wrong locations, required 0", bad);
        end
    endtask

    task automatic test_timeout();
        int dc;
        dc = done_count;
        $display("frame addr=30 len=04 aborted by idle timeout");
        send_byte(8'h30);
        send_byte(8'h04);
        exp_q.push_back({8'h30, 8'h01});
        send_byte(8'h01);
        exp_q.push_back({8'h31, 8'h02});
        send_byte(8'h02);
        repeat (TO + 5) @(posedge clk);
        #1;
        checks++;
        if ({err, busy, in_ready} !== 3'b101 || done_count !== dc) begin
            errors++;
            $display("FAIL timeout_state: got err=%b busy=%b ready=%b dones=%0d, required 1 0 1 0",
                     err, busy, in_ready, done_count - dc);
        end
        send_byte(8'h40);
        checks++;
        if (err !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL err_clear: got err=%b busy=%b, required 0 1", err, busy);
        end
        send_byte(8'h02);
        exp_q.push_back({8'h40, 8'h77});
        send_byte(8'h77);
        exp_q.push_back({8'h41, 8'h88});
        send_byte(8'h88);
`ifdef CHECKSUM_EN
        send_byte(8'h00 - (8'h40 + 8'h02 + 8'h77 + 8'h88));
`endif
        @(posedge clk); #1;
        checks++;
        if ({mem_model[8'h30], mem_model[8'h31], mem_model[8'h40], mem_model[8'h41]} !== 32'h01027788 || err !== 1'b0) begin
            errors++;
            $display("FAIL timeout_recover: got %h %h %h %h err=%b, required 01 02 77 88 err=0",
                     mem_model[8'h30], mem_model[8'h31], mem_model[8'h40], mem_model[8'h41], err);
        end
    endtask

    task automatic test_rst_abort();
        int wc;
        $display("frame addr=50 len=04 aborted by reset");
        send_byte(8'h50);
        send_byte(8'h04);
        exp_q.push_back({8'h50, 8'hA1});
        send_byte(8'hA1);
        in_valid = 1'b1;
        in_data  = 8'hA2;
        rst      = 1'b1;
        @(posedge clk); #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        wc = write_count;
        checks++;
        if (busy !== 1'b0 || mem_write_en !== 1'b0) begin
            errors++;
            $display("FAIL rst_abort_state: got busy=%b we=%b, required 0 0", busy, mem_write_en);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (write_count !== wc || mem_model[8'h51] !== 8'h51 || mem_model[8'h50] !== 8'hA1) begin
            errors++;
            $display("FAIL rst_abort_mem: got extra_writes=%0d mem50=%h mem51=%h, required 0 A1 51",
                     write_count - wc, mem_model[8'h50], mem_model[8'h51]);
        end
    endtask

`ifdef CHECKSUM_EN
    task automatic test_checksum();
        int dc;
        pl_q = '{8'h05};
        send_frame(8'h20, 8'h01, 1'b0);
        checks++;
        if (err !== 1'b0 || mem_model[8'h20] !== 8'h05) begin
            errors++;
            $display("FAIL chk_good: got err=%b mem20=%h, required 0 05", err, mem_model[8'h20]);
        end
        mem_model[8'h20] = 8'h00;
        dc = done_count;
        send_frame(8'h20, 8'h01, 1'b1);
        checks++;
        if (err !== 1'b1 || mem_model[8'h20] !== 8'h05 || done_count - dc !== 1) begin
            errors++;
            $display("FAIL chk_bad: got err=%b mem20=%h dones=%0d, required 1 05 1",
                     err, mem_model[8'h20], done_count - dc);
        end
    endtask
`endif

    initial begin
        for (int i = 0; i < 256; i++) mem_model[i] = 8'h00;
        test_reset();
        test_back_to_back();
        test_wrap();
        test_full_frame();
        test_timeout();
        test_rst_abort();
`ifdef CHECKSUM_EN
        test_checksum();
`endif
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() !== 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending writes, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
